// File: rtl/bcp_pkg.sv
// bcp_pkg: shared types for the BCP clause feeder and the assignment logic
// that consumes its implications.
package bcp_pkg;

  localparam int BCP_VAR_NUM = 8;
  localparam int BCP_SZ_W    = $clog2(BCP_VAR_NUM + 1);

  // One stored clause: literal polarity (1 = positive), presence mask, literal count.
  typedef struct packed {
    logic [BCP_VAR_NUM-1:0] lit_type;
    logic [BCP_VAR_NUM-1:0] mask;
    logic [BCP_SZ_W-1:0]    size;
  } clause_word_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EVAL,
    ST_SAMPLE,
    ST_REPORT
  } feeder_state_t;

  // A clause can never hold more literals than there are variables.
  function automatic logic [BCP_SZ_W-1:0] clamp_size(input logic [BCP_SZ_W-1:0] size);
    return (size > BCP_SZ_W'(BCP_VAR_NUM)) ? BCP_SZ_W'(BCP_VAR_NUM) : size;
  endfunction

endpackage

// File: rtl/bcp_lowest_onehot.sv
// bcp_lowest_onehot: priority encoder returning the index of the lowest set
// bit and a flag that any bit is set.
module bcp_lowest_onehot #(
  parameter int W     = 8,
  parameter int IDX_W = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]     i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_nonzero
);

  // Scan from the top down so the lowest set bit is the last one to win.
  always_comb begin
    o_idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = IDX_W'(i);
    end
  end

  assign o_nonzero = |i_vec;

endmodule

// File: rtl/bcp_clause_feeder.sv
// bcp_clause_feeder: holds a clause store and, on start, streams each clause
// to the BCP checker (load, size x evaluate, sample), reporting every unit
// clause as a (variable, value) implication.
// Optional build macro BCP_FEEDER_STOP_ON_UNIT_EN: end the scan at the first
// unit clause instead of scanning all requested clauses.
// VAR_NUM must equal bcp_pkg::BCP_VAR_NUM because the clause word is a package type.
module bcp_clause_feeder
  import bcp_pkg::*;
#(
  parameter int VAR_NUM    = BCP_VAR_NUM,
  parameter int CLAUSE_NUM = 16,
  parameter int SZ_W       = $clog2(VAR_NUM + 1)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [$clog2(CLAUSE_NUM)-1:0] wr_addr,
  input  logic [VAR_NUM-1:0]            wr_type,
  input  logic [VAR_NUM-1:0]            wr_mask,
  input  logic [SZ_W-1:0]               wr_size,
  input  logic                          start,
  input  logic [$clog2(CLAUSE_NUM):0]   num_clauses,
  input  logic [VAR_NUM-1:0]            free,
  output logic                          chk_initial,
  output logic                          chk_en,
  output logic [VAR_NUM-1:0]            chk_clause_type,
  output logic [VAR_NUM-1:0]            chk_clause_mask,
  output logic [SZ_W-1:0]               chk_clause_size,
  output logic [VAR_NUM-1:0]            chk_free,
  input  logic                          chk_unit_exist,
  output logic                          busy,
  output logic                          done,
  output logic                          impl_valid,
  output logic [$clog2(VAR_NUM)-1:0]    impl_var,
  output logic                          impl_value,
  output logic [$clog2(CLAUSE_NUM)-1:0] clause_idx,
  output logic [$clog2(CLAUSE_NUM):0]   unit_count
);

  localparam int AW = $clog2(CLAUSE_NUM);
  localparam int CW = AW + 1;
  localparam int VW = $clog2(VAR_NUM);

`ifdef BCP_FEEDER_STOP_ON_UNIT_EN
  localparam bit STOP_ON_UNIT = 1'b1;
`else
  localparam bit STOP_ON_UNIT = 1'b0;
`endif

  feeder_state_t   r_state, w_next;
  clause_word_t    r_store [CLAUSE_NUM];
  clause_word_t    w_word;
  logic [SZ_W-1:0] w_size, r_cnt;
  logic [VAR_NUM-1:0] r_free;
  logic [CW-1:0]   r_num, w_num_clamped, r_unit_count;
  logic [AW-1:0]   r_clause_idx;
  logic [VW-1:0]   r_impl_var, w_low_idx;
  logic            r_verdict, r_done, r_impl_valid, r_impl_value;
  logic            w_low_nz, w_hit, w_last;

  // Clause store write port; only the idle sequencer accepts writes.
  // NOTE: storage arrays carry no reset; their contents are only meaningful once written.
  always_ff @(posedge clock) begin
    if (wr_en && r_state == ST_IDLE) begin
      r_store[wr_addr] <= '{lit_type: wr_type, mask: wr_mask, size: wr_size};
    end
  end

  assign w_word = r_store[r_clause_idx];
  assign w_size = clamp_size(w_word.size);

  bcp_lowest_onehot #(.W(VAR_NUM), .IDX_W(VW)) u_lowest (
    .i_vec     (w_word.mask & r_free),
    .o_idx     (w_low_idx),
    .o_nonzero (w_low_nz)
  );

  // A verdict with no free literal left is a conflict and raises nothing.
  assign w_hit  = r_verdict & w_low_nz;
  assign w_last = ((CW'(r_clause_idx) + CW'(1)) == r_num) || (STOP_ON_UNIT && w_hit);

  // The clause index cannot run past the store, so oversized scan requests are capped.
  assign w_num_clamped = (num_clauses > CW'(CLAUSE_NUM)) ? CW'(CLAUSE_NUM) : num_clauses;

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic.
  // NOTE: the default assignment covers every path, so no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (start && num_clauses != '0) w_next = ST_LOAD;
      ST_LOAD:   w_next = (w_size == '0) ? ST_REPORT : ST_EVAL;
      ST_EVAL:   if (r_cnt == w_size) w_next = ST_SAMPLE;
      ST_SAMPLE: w_next = ST_REPORT;
      ST_REPORT: w_next = w_last ? ST_IDLE : ST_LOAD;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Checker-facing outputs; the clause word is gated so idle outputs read zero.
  always_comb begin
    chk_initial     = 1'b0;
    chk_en          = 1'b0;
    busy            = (r_state != ST_IDLE);
    chk_clause_type = '0;
    chk_clause_mask = '0;
    chk_clause_size = '0;
    case (r_state)
      ST_LOAD: chk_initial = 1'b1;
      ST_EVAL: chk_en      = 1'b1;
      default: ;
    endcase
    if (busy) begin
      chk_clause_type = w_word.lit_type;
      chk_clause_mask = w_word.mask;
      chk_clause_size = w_size;
    end
  end

  // Scan datapath: latched request, eval counter, verdict and reported results.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_free       <= '0;
      r_num        <= '0;
      r_cnt        <= '0;
      r_clause_idx <= '0;
      r_unit_count <= '0;
      r_verdict    <= 1'b0;
      r_done       <= 1'b0;
      r_impl_valid <= 1'b0;
      r_impl_var   <= '0;
      r_impl_value <= 1'b0;
    end else begin
      r_done       <= 1'b0;
      r_impl_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (num_clauses != '0) begin
              r_free       <= free;
              r_num        <= w_num_clamped;
              r_unit_count <= '0;
              r_clause_idx <= '0;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          r_cnt     <= SZ_W'(1);
          r_verdict <= 1'b0;
        end
        ST_EVAL:   if (r_cnt != w_size) r_cnt <= r_cnt + SZ_W'(1);
        ST_SAMPLE: r_verdict <= chk_unit_exist;
        ST_REPORT: begin
          if (w_hit) begin
            r_impl_valid <= 1'b1;
            r_impl_var   <= w_low_idx;
            r_impl_value <= w_word.lit_type[w_low_idx];
            r_unit_count <= r_unit_count + CW'(1);
          end
          if (w_last) r_done <= 1'b1;
          else        r_clause_idx <= r_clause_idx + AW'(1);
        end
        default: ;
      endcase
    end
  end

  assign chk_free   = r_free;
  assign done       = r_done;
  assign impl_valid = r_impl_valid;
  assign impl_var   = r_impl_var;
  assign impl_value = r_impl_value;
  assign clause_idx = r_clause_idx;
  assign unit_count = r_unit_count;

endmodule

// File: tb/tb_bcp_clause_feeder.sv
// tb_bcp_clause_feeder: directed scenarios for bcp_clause_feeder with a small
// checker model answering unit verdicts from a per-clause table.
`timescale 1ns/1ps
module tb_bcp_clause_feeder;

  localparam int VAR_NUM    = 8;
  localparam int CLAUSE_NUM = 16;
  localparam int SZ_W       = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         wr_en = 1'b0;
  logic [3:0]   wr_addr = '0;
  logic [7:0]   wr_type = '0, wr_mask = '0;
  logic [3:0]   wr_size = '0;
  logic         start = 1'b0;
  logic [4:0]   num_clauses = '0;
  logic [7:0]   free = '0;
  logic         chk_initial, chk_en, chk_unit_exist;
  logic [7:0]   chk_clause_type, chk_clause_mask, chk_free;
  logic [3:0]   chk_clause_size;
  logic         busy, done, impl_valid, impl_value;
  logic [2:0]   impl_var;
  logic [3:0]   clause_idx;
  logic [4:0]   unit_count;

  int n_cmp = 0;
  int n_err = 0;

  bcp_clause_feeder #(.VAR_NUM(VAR_NUM), .CLAUSE_NUM(CLAUSE_NUM), .SZ_W(SZ_W)) dut (
    .clock(clock), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_type(wr_type), .wr_mask(wr_mask), .wr_size(wr_size),
    .start(start), .num_clauses(num_clauses), .free(free),
    .chk_initial(chk_initial), .chk_en(chk_en),
    .chk_clause_type(chk_clause_type), .chk_clause_mask(chk_clause_mask),
    .chk_clause_size(chk_clause_size), .chk_free(chk_free),
    .chk_unit_exist(chk_unit_exist),
    .busy(busy), .done(done), .impl_valid(impl_valid), .impl_var(impl_var),
    .impl_value(impl_value), .clause_idx(clause_idx), .unit_count(unit_count)
  );

  always #5 clock = ~clock;

  // Checker model: verdict valid the cycle after the last evaluate strobe.
  logic unit_tbl [CLAUSE_NUM];
  logic tb_prev_en = 1'b0;
  always @(posedge clock) tb_prev_en <= chk_en;
  assign chk_unit_exist = tb_prev_en & unit_tbl[clause_idx];

  // Activity monitor, sampled on the falling edge.
  int         n_init = 0, n_en = 0, n_impl = 0, n_done = 0;
  logic [2:0] mon_var = '0;
  logic       mon_val = 1'b0, mon_impl_at_done = 1'b0;
  logic [7:0] cap_type [CLAUSE_NUM];
  logic [7:0] cap_mask [CLAUSE_NUM];
  logic [3:0] cap_size [CLAUSE_NUM];
  always @(negedge clock) begin
    if (chk_initial) begin
      n_init <= n_init + 1;
      cap_type[clause_idx] <= chk_clause_type;
      cap_mask[clause_idx] <= chk_clause_mask;
      cap_size[clause_idx] <= chk_clause_size;
    end
    if (chk_en) n_en <= n_en + 1;
    if (impl_valid) begin
      n_impl <= n_impl + 1;
      mon_var <= impl_var;
      mon_val <= impl_value;
      mon_impl_at_done <= done;
    end
    if (done) n_done <= n_done + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic write_clause(input logic [3:0] a, input logic [7:0] t, input logic [7:0] m,
                              input logic [3:0] s);
    wr_addr = a; wr_type = t; wr_mask = m; wr_size = s; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic clear_units();
    for (int i = 0; i < CLAUSE_NUM; i++) unit_tbl[i] = 1'b0;
  endtask

  // Leaves the bench one cycle after start, i.e. in the first busy cycle.
  task automatic start_scan(input logic [4:0] n, input logic [7:0] f);
    num_clauses = n; free = f; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, output int lat);
    bit ok = 1'b0;
    lat = 0;
    while (lat < budget && !ok) begin
      tick();
      lat++;
      if (done === 1'b1) ok = 1'b1;
    end
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL %s_timeout: no done within %0d cycles", name, budget); end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_cmp++; if ({busy, done, impl_valid, chk_initial, chk_en} !== 5'b0) begin
      n_err++; $display("FAIL reset_strobes: got %b want 00000", {busy, done, impl_valid, chk_initial, chk_en}); end
    n_cmp++; if ({unit_count, clause_idx, impl_var, impl_value} !== 13'b0) begin
      n_err++; $display("FAIL reset_status: got %h want 0", {unit_count, clause_idx, impl_var, impl_value}); end
    n_cmp++; if ({chk_clause_type, chk_clause_mask, chk_clause_size, chk_free} !== 28'b0) begin
      n_err++; $display("FAIL reset_chk_word: got %h want 0", {chk_clause_type, chk_clause_mask, chk_clause_size, chk_free}); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_zero_scan();
    start_scan(5'd0, 8'hFF);
    n_cmp++; if ({done, busy} !== 2'b10) begin n_err++; $display("FAIL zero_scan_done: got done,busy=%b want 10", {done, busy}); end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL zero_scan_pulse: got done=%b want 0", done); end
  endtask

  task automatic test_lone_unit();
    int lat, s_en, s_init, s_impl;
    clear_units(); unit_tbl[0] = 1'b1;
    write_clause(4'd0, 8'h01, 8'h03, 4'd2);
    s_en = n_en; s_init = n_init; s_impl = n_impl;
    start_scan(5'd1, 8'h01);
    n_cmp++; if ({busy, chk_initial} !== 2'b11) begin n_err++; $display("FAIL lone_load: got busy,init=%b want 11", {busy, chk_initial}); end
    n_cmp++; if ({chk_clause_mask, chk_clause_size, chk_free} !== {8'h03, 4'd2, 8'h01}) begin
      n_err++; $display("FAIL lone_word: got %h want 03201", {chk_clause_mask, chk_clause_size, chk_free}); end
    wait_done("lone", 50, lat);
    n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL lone_latency: got %0d want 5", lat); end
    n_cmp++; if (n_en - s_en !== 2) begin n_err++; $display("FAIL lone_en_cycles: got %0d want 2", n_en - s_en); end
    n_cmp++; if (n_init - s_init !== 1) begin n_err++; $display("FAIL lone_loads: got %0d want 1", n_init - s_init); end
    n_cmp++; if (n_impl - s_impl !== 1) begin n_err++; $display("FAIL lone_impl_count: got %0d want 1", n_impl - s_impl); end
    n_cmp++; if ({impl_valid, impl_var, impl_value} !== {1'b1, 3'd0, 1'b1}) begin
      n_err++; $display("FAIL lone_impl: got valid,var,val=%b want 1_000_1", {impl_valid, impl_var, impl_value}); end
    n_cmp++; if (unit_count !== 5'd1) begin n_err++; $display("FAIL lone_unit_count: got %0d want 1", unit_count); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL lone_busy_fall: got %b want 0", busy); end
    tick();
    n_cmp++; if ({done, impl_valid} !== 2'b00) begin n_err++; $display("FAIL lone_pulses: got %b want 00", {done, impl_valid}); end
  endtask

  task automatic test_three_nonunit();
    int lat, s_en, s_init, s_impl;
    clear_units();
    write_clause(4'd0, 8'h00, 8'h01, 4'd1);
    write_clause(4'd1, 8'h00, 8'h06, 4'd2);
    write_clause(4'd2, 8'h00, 8'h38, 4'd3);
    s_en = n_en; s_init = n_init; s_impl = n_impl;
    start_scan(5'd3, 8'hFF);
    wait_done("three", 100, lat);
    n_cmp++; if (lat !== 15) begin n_err++; $display("FAIL three_latency: got %0d want 15", lat); end
    n_cmp++; if (n_init - s_init !== 3) begin n_err++; $display("FAIL three_loads: got %0d want 3", n_init - s_init); end
    n_cmp++; if (n_en - s_en !== 6) begin n_err++; $display("FAIL three_en_cycles: got %0d want 6", n_en - s_en); end
    n_cmp++; if (n_impl - s_impl !== 0) begin n_err++; $display("FAIL three_impl_count: got %0d want 0", n_impl - s_impl); end
    n_cmp++; if ({unit_count, clause_idx} !== {5'd0, 4'd2}) begin
      n_err++; $display("FAIL three_status: got units=%0d idx=%0d want 0/2", unit_count, clause_idx); end
  endtask

  task automatic test_size_zero();
    int lat, s_en, s_init, s_impl;
    clear_units(); unit_tbl[1] = 1'b1;
    write_clause(4'd0, 8'h00, 8'h03, 4'd2);
    write_clause(4'd1, 8'h04, 8'h04, 4'd0);
    s_en = n_en; s_init = n_init; s_impl = n_impl;
    start_scan(5'd2, 8'hFF);
    wait_done("size0", 100, lat);
    n_cmp++; if (lat !== 7) begin n_err++; $display("FAIL size0_latency: got %0d want 7", lat); end
    n_cmp++; if (n_en - s_en !== 2) begin n_err++; $display("FAIL size0_en_cycles: got %0d want 2", n_en - s_en); end
    n_cmp++; if (n_init - s_init !== 2) begin n_err++; $display("FAIL size0_loads: got %0d want 2", n_init - s_init); end
    n_cmp++; if (n_impl - s_impl !== 0) begin n_err++; $display("FAIL size0_impl_count: got %0d want 0", n_impl - s_impl); end
  endtask

  task automatic test_size_clamp();
    int lat, s_en;
    clear_units();
    write_clause(4'd0, 8'h00, 8'h01, 4'd12);
    s_en = n_en;
    start_scan(5'd1, 8'hFF);
    wait_done("clamp", 100, lat);
    n_cmp++; if (lat !== 11) begin n_err++; $display("FAIL clamp_latency: got %0d want 11", lat); end
    n_cmp++; if (n_en - s_en !== 8) begin n_err++; $display("FAIL clamp_en_cycles: got %0d want 8", n_en - s_en); end
    n_cmp++; if (cap_size[0] !== 4'd8) begin n_err++; $display("FAIL clamp_chk_size: got %0d want 8", cap_size[0]); end
  endtask

  // Units at clauses 1 (var 3 -> 1) and 3 (var 5 -> 0) with free = 0x2A.
  task automatic test_multi_unit();
    int lat, s_impl;
    clear_units(); unit_tbl[1] = 1'b1; unit_tbl[3] = 1'b1;
    write_clause(4'd0, 8'h00, 8'h01, 4'd1);
    write_clause(4'd1, 8'h08, 8'h0C, 4'd1);
    write_clause(4'd2, 8'h00, 8'h02, 4'd1);
    write_clause(4'd3, 8'h00, 8'h30, 4'd1);
    s_impl = n_impl;
    start_scan(5'd4, 8'h2A);
    wait_done("multi", 100, lat);
`ifdef BCP_FEEDER_STOP_ON_UNIT_EN
    n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL multi_latency: got %0d want 8", lat); end
    n_cmp++; if (n_impl - s_impl !== 1) begin n_err++; $display("FAIL multi_impl_count: got %0d want 1", n_impl - s_impl); end
    n_cmp++; if ({clause_idx, unit_count} !== {4'd1, 5'd1}) begin
      n_err++; $display("FAIL multi_status: got idx=%0d units=%0d want 1/1", clause_idx, unit_count); end
    n_cmp++; if ({mon_var, mon_val} !== {3'd3, 1'b1}) begin
      n_err++; $display("FAIL multi_impl: got var=%0d val=%b want 3/1", mon_var, mon_val); end
`else
    n_cmp++; if (lat !== 16) begin n_err++; $display("FAIL multi_latency: got %0d want 16", lat); end
    n_cmp++; if (n_impl - s_impl !== 2) begin n_err++; $display("FAIL multi_impl_count: got %0d want 2", n_impl - s_impl); end
    n_cmp++; if ({clause_idx, unit_count} !== {4'd3, 5'd2}) begin
      n_err++; $display("FAIL multi_status: got idx=%0d units=%0d want 3/2", clause_idx, unit_count); end
    n_cmp++; if ({mon_var, mon_val} !== {3'd5, 1'b0}) begin
      n_err++; $display("FAIL multi_impl: got var=%0d val=%b want 5/0", mon_var, mon_val); end
`endif
    n_cmp++; if (mon_impl_at_done !== 1'b1) begin n_err++; $display("FAIL multi_impl_with_done: got %b want 1", mon_impl_at_done); end
  endtask

  task automatic test_reset_mid_eval();
    int lat, s_done;
    clear_units(); unit_tbl[0] = 1'b1;
    write_clause(4'd0, 8'h01, 8'h03, 4'd2);
    write_clause(4'd1, 8'h00, 8'h80, 4'd3);
    start_scan(5'd2, 8'h01);
    repeat (6) tick();
    n_cmp++; if ({chk_en, unit_count} !== {1'b1, 5'd1}) begin
      n_err++; $display("FAIL rst_pre: got en=%b units=%0d want 1/1", chk_en, unit_count); end
    s_done = n_done;
    reset = 1'b1;
    tick();
    n_cmp++; if ({busy, chk_en, unit_count} !== 7'b0) begin
      n_err++; $display("FAIL rst_abort: got busy=%b en=%b units=%0d want 0/0/0", busy, chk_en, unit_count); end
    reset = 1'b0;
    repeat (10) tick();
    n_cmp++; if (n_done - s_done !== 0) begin n_err++; $display("FAIL rst_no_done: got %0d done pulses want 0", n_done - s_done); end
    start_scan(5'd1, 8'h01);
    wait_done("rst_restart", 50, lat);
    n_cmp++; if ({lat, unit_count, impl_var} !== {32'd5, 5'd1, 3'd0}) begin
      n_err++; $display("FAIL rst_restart: got lat=%0d units=%0d var=%0d want 5/1/0", lat, unit_count, impl_var); end
  endtask

  task automatic test_busy_writes();
    int lat, s_init, s_done;
    clear_units();
    write_clause(4'd0, 8'h00, 8'h01, 4'd1);
    write_clause(4'd1, 8'h00, 8'h02, 4'd1);
    write_clause(4'd2, 8'h55, 8'h0F, 4'd4);
    s_init = n_init; s_done = n_done;
    start_scan(5'd3, 8'h00);
    wr_addr = 4'd2; wr_type = 8'hAA; wr_mask = 8'hF0; wr_size = 4'd1; wr_en = 1'b1;
    num_clauses = 5'd1; start = 1'b1;
    tick();
    wr_en = 1'b0; start = 1'b0;
    wait_done("busy_wr", 100, lat);
    // Counted from the second busy cycle, so one less than the 15-cycle scan.
    n_cmp++; if (lat !== 14) begin n_err++; $display("FAIL busy_latency: got %0d want 14", lat); end
    n_cmp++; if (n_init - s_init !== 3) begin n_err++; $display("FAIL busy_loads: got %0d want 3", n_init - s_init); end
    repeat (5) tick();
    n_cmp++; if ({n_done - s_done, busy} !== {32'd1, 1'b0}) begin
      n_err++; $display("FAIL busy_no_restart: got dones=%0d busy=%b want 1/0", n_done - s_done, busy); end
    start_scan(5'd3, 8'h00);
    wait_done("busy_readback", 100, lat);
    n_cmp++; if ({cap_type[2], cap_mask[2], cap_size[2]} !== {8'h55, 8'h0F, 4'd4}) begin
      n_err++; $display("FAIL busy_store: got %h want 550f4", {cap_type[2], cap_mask[2], cap_size[2]}); end
  endtask

  initial begin
    clear_units();
    test_reset();
    test_zero_scan();
    test_lone_unit();
    test_three_nonunit();
    test_size_zero();
    test_size_clamp();
    test_multi_unit();
    test_reset_mid_eval();
    test_busy_writes();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bcp_clause_feeder.md
# bcp_clause_feeder

Sequencer on the driving side of the clause-checker interface. Holds a small clause store, and on `start` streams each clause to the BCP checker. For every clause it issues the load strobe, then the evaluate strobes, then samples the checker's unit verdict. Each detected unit clause is reported to the decision/assignment logic as a (variable, value) implication.

## Interface
- `VAR_NUM`, 8: variables per clause word.
- `CLAUSE_NUM`, 16: clause store depth.
- `SZ_W`, `$clog2(VAR_NUM+1)`: clause-size width.
- `clock` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `wr_en` in 1: clause-store write strobe.
- `wr_addr` in `$clog2(CLAUSE_NUM)`: store address.
- `wr_type` in `VAR_NUM`: literal polarity per variable; 1 = positive literal.
- `wr_mask` in `VAR_NUM`: variable present in clause.
- `wr_size` in `SZ_W`: literal count.
- `start` in 1: begin a scan pulse.
- `num_clauses` in `$clog2(CLAUSE_NUM)+1`: clauses to scan; sampled on `start`.
- `free` in `VAR_NUM`: unassigned variables; sampled on `start`.
- `chk_initial` out 1: checker load strobe.
- `chk_en` out 1: checker evaluate strobe.
- `chk_clause_type`, `chk_clause_mask` out `VAR_NUM`: clause word to the checker.
- `chk_clause_size` out `SZ_W`: clause size to the checker.
- `chk_free` out `VAR_NUM`: free vector to the checker.
- `chk_unit_exist` in 1: checker unit verdict.
- `busy` out 1: scan in progress.
- `done` out 1: one-cycle pulse at scan end.
- `impl_valid` out 1: one-cycle implication pulse.
- `impl_var` out `$clog2(VAR_NUM)`: implied variable index.
- `impl_value` out 1: implied value.
- `clause_idx` out `$clog2(CLAUSE_NUM)`: clause currently or last handled.
- `unit_count` out `$clog2(CLAUSE_NUM)+1`: units found in the last scan.

## Operation
- FSM states: IDLE, LOAD, EVAL, SAMPLE, REPORT.
- IDLE:
  - `wr_en` writes the store.
  - `start` with `num_clauses`≠0 latches `free` and `num_clauses`, clears `unit_count` and `clause_idx`, and moves to LOAD.
  - `start` with `num_clauses`=0 pulses `done` next cycle and stays in IDLE.
- LOAD:
  - Drives `chk_initial`=1 and the clause word for `clause_idx` on `chk_*`.
  - Moves to EVAL with the eval counter set to 1.
  - If size is 0, goes straight to REPORT as not-unit; no `chk_en` is issued.
- EVAL:
  - Drives `chk_en`=1 for exactly `size` cycles.
  - `chk_clause_*` and `chk_free` stay stable throughout.
  - Moves to SAMPLE after the cycle where counter==size.
- SAMPLE:
  - `chk_en`=0.
  - Captures `chk_unit_exist`, which becomes valid the cycle after the last `chk_en`.
  - Moves to REPORT.
- REPORT, when the captured verdict is 1:
  - `impl_valid`=1 and `unit_count`+1.
  - `impl_var` is the lowest set bit of (mask & latched free).
  - `impl_value` is `type[impl_var]`.
  - If mask & free is 0, no implication is raised (conflict, left to the consumer).
- REPORT, next step:
  - If `clause_idx`==`num_clauses`−1: pulse `done` and go to IDLE.
  - Otherwise increment `clause_idx` and go to LOAD.
- Writes while `busy` are dropped. `start` while `busy` is ignored.
- Size values above `VAR_NUM` are clamped to `VAR_NUM`.

## Timing
- Reset values:
  - All outputs are 0 and the FSM is in IDLE.
  - The store contents are not reset.
- Reset mid-scan aborts immediately: no `done`, `unit_count` reads 0.
- Per-clause latency is size+3 cycles (LOAD + size×EVAL + SAMPLE + REPORT). A size-0 clause takes 2 cycles.
- `busy` rises the cycle after `start` and falls with `done`.
- `impl_valid` and `done` can assert in the same cycle, on the last clause.
- Store read is combinational from registered `clause_idx`.
- A write to the address being scanned cannot occur, because writes are dropped while `busy`.

## Configuration
- `BCP_FEEDER_STOP_ON_UNIT_EN` defined: the scan ends at the first unit clause. REPORT pulses `impl_valid` and `done` together and returns to IDLE, so `unit_count` ≤ 1.
- `BCP_FEEDER_STOP_ON_UNIT_EN` undefined: all `num_clauses` clauses are scanned, and every unit is reported.

## Structure
- Shared package `bcp_pkg` holds:
  - `VAR_NUM` default;
  - the clause-word struct (type, mask, size);
  - the FSM state enum.
- One sub-module, `bcp_lowest_onehot`: a priority encoder giving the lowest set bit index plus a nonzero flag. It is reused by later assignment logic.

## Test plan
- Lone unit clause:
  - Store[0]: type=0x01, mask=0x03, size=2. `free`=0x01, `num_clauses`=1, checker model asserts unit.
  - Expected: `chk_en` high 2 cycles, then `impl_valid` with `impl_var`=0, `impl_value`=1, then `done`; `unit_count`=1.
- Three clauses of sizes 1/2/3, all non-unit:
  - Expected: `chk_initial` pulses 3 times; `chk_en` totals 6 cycles; `done` 15 cycles after `busy` rises; no `impl_valid`.
- Size-0 clause at index 1 of 2:
  - Expected: no `chk_en` for that clause; `done` after 2+5 cycles (clause 0 has size 2).
- Macro defined, units at indices 1 and 3 of 4:
  - Expected: a single `impl_valid`, coinciding with `done`; `clause_idx`=1.
- Reset asserted during EVAL:
  - Expected: `busy`, `chk_en` and `unit_count` are 0 next edge; no `done`.
  - A new `start` after reset completes normally.
- `wr_en` and `start` while `busy`:
  - Expected: the store is unchanged (read back after `done`), and the scan is not restarted.
